branch_resolve: RTL

- Consumer end of the ALU compare/flag interface.
- Takes the S/Z/V/N outputs of a compare or subtract op, plus branch opcode, PC and immediate, then resolves taken/not-taken and target.
- Flags a misprediction against the fetch-stage prediction.
- Sits between the ALU and the PC-redirect logic; valid/ready handshake on both sides, 2-entry skid buffer, saturating statistics counters.

---
 rtl/branch_resolve_if.sv | 40 ++++
 rtl/branch_resolve.sv | 100 ++++++++++
 2 files changed

// File: rtl/branch_resolve_if.sv
// rtl/branch_resolve_if.sv - ALU-compare-to-redirect handshake bundle for branch_resolve
interface branch_resolve_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       br_op;
  logic [WIDTH-1:0] alu_s;
  logic             alu_z;
  logic             alu_v;
  logic             alu_n;
  logic [WIDTH-1:0] pc_plus4;
  logic [15:0]      imm;
  logic             pred_taken;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic             taken;
  logic [WIDTH-1:0] target;
  logic             mispredict;
  logic             illegal;
  logic             ovf;
  logic [CNT_W-1:0] cnt_branches;
  logic [CNT_W-1:0] cnt_mispred;

  modport master (
    output in_valid, br_op, alu_s, alu_z, alu_v, alu_n, pc_plus4, imm, pred_taken,
    output flush, out_ready,
    input  in_ready, out_valid, taken, target, mispredict, illegal, ovf,
    input  cnt_branches, cnt_mispred
  );

  modport slave (
    input  in_valid, br_op, alu_s, alu_z, alu_v, alu_n, pc_plus4, imm, pred_taken,
    input  flush, out_ready,
    output in_ready, out_valid, taken, target, mispredict, illegal, ovf,
    output cnt_branches, cnt_mispred
  );
endinterface

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - branch direction/target resolver with 2-entry skid buffer and stats
module branch_resolve #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  branch_resolve_if.slave bus
);

  typedef struct packed {
    logic             taken;
    logic             illegal;
    logic             mispredict;
    logic             ovf;
    logic [WIDTH-1:0] target;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  entry_t           res;
  entry_t           e0;
  entry_t           e1;
  logic             v0;
  logic             v1;
  logic             accept;
  logic             drain;
  logic [WIDTH-1:0] offset;
  logic [CNT_W-1:0] cnt_br_q;
  logic [CNT_W-1:0] cnt_mp_q;

  // Word offset sign-extended to byte offset; wrap past 2^WIDTH is intentional.
  assign offset = {{(WIDTH-18){bus.imm[15]}}, bus.imm, 2'b00};

  always_comb begin
    res         = '0;
    res.ovf     = bus.alu_v;
    case (bus.br_op)
      3'd0:    res.taken = bus.alu_s[0];
      3'd1:    res.taken = ~bus.alu_s[0];
      3'd2:    res.taken = bus.alu_n | bus.alu_z;
      3'd3:    res.taken = ~(bus.alu_n | bus.alu_z);
      3'd4:    res.taken = bus.alu_n;
      3'd5:    res.taken = ~bus.alu_n;
      default: res.illegal = 1'b1;
    endcase
    res.target     = res.taken ? bus.pc_plus4 + offset : bus.pc_plus4;
    res.mispredict = res.illegal | (res.taken != bus.pred_taken);
  end

  // in_ready depends only on skid occupancy, so no path from out_ready.
  assign accept = bus.in_valid & ~v1 & ~bus.flush;
  assign drain  = v0 & bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      v0       <= 1'b0;
      v1       <= 1'b0;
      e0       <= '0;
      e1       <= '0;
      cnt_br_q <= '0;
      cnt_mp_q <= '0;
    end else begin
      if (drain) begin
        if (cnt_br_q != CNT_MAX) cnt_br_q <= cnt_br_q + 1'b1;
        if (e0.mispredict && cnt_mp_q != CNT_MAX) cnt_mp_q <= cnt_mp_q + 1'b1;
      end
      if (bus.flush) begin
        v0 <= 1'b0;
        v1 <= 1'b0;
      end else begin
        if (drain) begin
          v0 <= v1;
          e0 <= e1;
          v1 <= 1'b0;
        end
        if (accept) begin
          if (!v0 || drain) begin
            e0 <= res;
            v0 <= 1'b1;
          end else begin
            e1 <= res;
            v1 <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.in_ready     = ~v1;
  assign bus.out_valid    = v0;
  assign bus.taken        = e0.taken;
  assign bus.target       = e0.target;
  assign bus.mispredict   = e0.mispredict;
  assign bus.illegal      = e0.illegal;
  assign bus.ovf          = e0.ovf;
  assign bus.cnt_branches = cnt_br_q;
  assign bus.cnt_mispred  = cnt_mp_q;

endmodule
